// File: rtl/tile_scheduler.sv
// Tile scheduler: walks K tiles (outer), pixel chunks (middle) and D tiles (inner)
// of one conv layer and presents each tile as a valid/ready command.
module tile_scheduler #(
    parameter int PIX_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [10:0]      in_D_i,
    input  logic [10:0]      out_K_i,
    input  logic [6:0]       tile_D_i,
    input  logic [6:0]       tile_K_i,
    input  logic [31:0]      tile_n_i,
    input  logic [6:0]       out_R_i,
    input  logic [6:0]       out_C_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [10:0]      k_base_o,
    output logic [6:0]       k_len_o,
    output logic [10:0]      d_base_o,
    output logic [6:0]       d_len_o,
    output logic [PIX_W-1:0] pix_base_o,
    output logic [PIX_W-1:0] pix_len_o,
    output logic             first_d_o,
    output logic             last_d_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [10:0]      in_d_r;
    logic [10:0]      out_k_r;
    logic [6:0]       tile_d_r;
    logic [6:0]       tile_k_r;
    logic [PIX_W-1:0] p_r;
    logic [PIX_W-1:0] chunk_r;

    logic [PIX_W-1:0] p_calc_s;
    logic [PIX_W-1:0] chunk_calc_s;
    logic             cfg_zero_s;
    logic [10:0]      cfg_in_d_s;
    logic [10:0]      cfg_out_k_s;
    logic [6:0]       cfg_tile_d_s;
    logic [6:0]       cfg_tile_k_s;
    logic [PIX_W-1:0] cfg_p_s;
    logic [PIX_W-1:0] cfg_chunk_s;
    logic [11:0]      d_sum_s;
    logic [11:0]      k_sum_s;
    logic [PIX_W:0]   pix_sum_s;
    logic             wrap_d_s;
    logic             wrap_pix_s;
    logic             wrap_k_s;
    logic             last_cmd_s;
    logic [10:0]      nxt_d_base_s;
    logic [10:0]      nxt_k_base_s;
    logic [PIX_W-1:0] nxt_pix_base_s;
    logic [10:0]      d_rem_s;
    logic [10:0]      k_rem_s;
    logic [PIX_W-1:0] pix_rem_s;
    logic [6:0]       nxt_d_len_s;
    logic [6:0]       nxt_k_len_s;
    logic [PIX_W-1:0] nxt_pix_len_s;
    logic             nxt_first_s;
    logic             nxt_last_s;
    logic             load_cmd_s;

    // Layer geometry from the raw inputs, used only while in SETUP
    always_comb begin
        p_calc_s = PIX_W'(out_R_i) * PIX_W'(out_C_i);
        if (tile_n_i < 32'(p_calc_s)) begin
            chunk_calc_s = PIX_W'(tile_n_i);
        end else begin
            chunk_calc_s = p_calc_s;
        end
        cfg_zero_s = (in_D_i == 11'd0) || (out_K_i == 11'd0) || (tile_D_i == 7'd0) ||
                     (tile_K_i == 7'd0) || (out_R_i == 7'd0) || (out_C_i == 7'd0) ||
                     (tile_n_i == 32'd0);
    end

    // Next command: in SETUP the first tile from the inputs, in ISSUE the successor
    // of the command currently presented, using 12-bit sums so bases never wrap
    always_comb begin
        cfg_in_d_s   = in_d_r;
        cfg_out_k_s  = out_k_r;
        cfg_tile_d_s = tile_d_r;
        cfg_tile_k_s = tile_k_r;
        cfg_p_s      = p_r;
        cfg_chunk_s  = chunk_r;
        d_sum_s      = {1'b0, d_base_o} + {5'd0, d_len_o};
        k_sum_s      = {1'b0, k_base_o} + {5'd0, k_len_o};
        pix_sum_s    = {1'b0, pix_base_o} + {1'b0, pix_len_o};
        wrap_d_s     = (d_sum_s >= {1'b0, in_d_r});
        wrap_pix_s   = (pix_sum_s >= {1'b0, p_r});
        wrap_k_s     = (k_sum_s >= {1'b0, out_k_r});
        last_cmd_s   = wrap_d_s && wrap_pix_s && wrap_k_s;
        if (state_r == SETUP) begin
            cfg_in_d_s     = in_D_i;
            cfg_out_k_s    = out_K_i;
            cfg_tile_d_s   = tile_D_i;
            cfg_tile_k_s   = tile_K_i;
            cfg_p_s        = p_calc_s;
            cfg_chunk_s    = chunk_calc_s;
            nxt_d_base_s   = 11'd0;
            nxt_pix_base_s = {PIX_W{1'b0}};
            nxt_k_base_s   = 11'd0;
        end else begin
            nxt_d_base_s = wrap_d_s ? 11'd0 : d_sum_s[10:0];
            if (wrap_d_s) begin
                nxt_pix_base_s = wrap_pix_s ? {PIX_W{1'b0}} : pix_sum_s[PIX_W-1:0];
            end else begin
                nxt_pix_base_s = pix_base_o;
            end
            nxt_k_base_s = (wrap_d_s && wrap_pix_s) ? k_sum_s[10:0] : k_base_o;
        end
        d_rem_s   = cfg_in_d_s - nxt_d_base_s;
        k_rem_s   = cfg_out_k_s - nxt_k_base_s;
        pix_rem_s = cfg_p_s - nxt_pix_base_s;
        if ({4'd0, cfg_tile_d_s} <= d_rem_s) begin
            nxt_d_len_s = cfg_tile_d_s;
        end else begin
            nxt_d_len_s = d_rem_s[6:0];
        end
        if ({4'd0, cfg_tile_k_s} <= k_rem_s) begin
            nxt_k_len_s = cfg_tile_k_s;
        end else begin
            nxt_k_len_s = k_rem_s[6:0];
        end
        if (cfg_chunk_s <= pix_rem_s) begin
            nxt_pix_len_s = cfg_chunk_s;
        end else begin
            nxt_pix_len_s = pix_rem_s;
        end
        nxt_first_s = (nxt_d_base_s == 11'd0);
        nxt_last_s  = (({1'b0, nxt_d_base_s} + {5'd0, nxt_d_len_s}) == {1'b0, cfg_in_d_s});
        if (state_r == SETUP) begin
            load_cmd_s = !abort_i && !cfg_zero_s;
        end else if (state_r == ISSUE) begin
            load_cmd_s = !abort_i && cmd_valid_o && cmd_ready_i && !last_cmd_s;
        end else begin
            load_cmd_s = 1'b0;
        end
    end

    // Command field registers; held stable until a transfer loads the successor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_base_o   <= 11'd0;
            k_len_o    <= 7'd0;
            d_base_o   <= 11'd0;
            d_len_o    <= 7'd0;
            pix_base_o <= {PIX_W{1'b0}};
            pix_len_o  <= {PIX_W{1'b0}};
            first_d_o  <= 1'b0;
            last_d_o   <= 1'b0;
        end else if (load_cmd_s) begin
            k_base_o   <= nxt_k_base_s;
            k_len_o    <= nxt_k_len_s;
            d_base_o   <= nxt_d_base_s;
            d_len_o    <= nxt_d_len_s;
            pix_base_o <= nxt_pix_base_s;
            pix_len_o  <= nxt_pix_len_s;
            first_d_o  <= nxt_first_s;
            last_d_o   <= nxt_last_s;
        end else begin
            k_base_o   <= k_base_o;
            k_len_o    <= k_len_o;
            d_base_o   <= d_base_o;
            d_len_o    <= d_len_o;
            pix_base_o <= pix_base_o;
            pix_len_o  <= pix_len_o;
            first_d_o  <= first_d_o;
            last_d_o   <= last_d_o;
        end
    end

    // Control FSM with registered status outputs and latched layer config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            in_d_r      <= 11'd0;
            out_k_r     <= 11'd0;
            tile_d_r    <= 7'd0;
            tile_k_r    <= 7'd0;
            p_r         <= {PIX_W{1'b0}};
            chunk_r     <= {PIX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cmd_valid_o <= 1'b0;
                    done_o      <= 1'b0;
                    if (start_i) begin
                        state_r <= SETUP;
                        busy_o  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                SETUP: begin
                    in_d_r   <= in_D_i;
                    out_k_r  <= out_K_i;
                    tile_d_r <= tile_D_i;
                    tile_k_r <= tile_K_i;
                    p_r      <= p_calc_s;
                    chunk_r  <= chunk_calc_s;
                    if (abort_i) begin
                        state_r <= DONE;
                        done_o  <= 1'b1;
                    end else if (cfg_zero_s) begin
                        state_r <= DONE;
                        done_o  <= 1'b1;
                        err_o   <= 1'b1;
                    end else begin
                        state_r     <= ISSUE;
                        cmd_valid_o <= 1'b1;
                        err_o       <= 1'b0;
                    end
                end
                ISSUE: begin
                    // abort wins even when a handshake completes on the same edge
                    if (abort_i || (cmd_valid_o && cmd_ready_i && last_cmd_s)) begin
                        state_r     <= DONE;
                        cmd_valid_o <= 1'b0;
                        done_o      <= 1'b1;
                    end else begin
                        state_r     <= ISSUE;
                        cmd_valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    cmd_valid_o <= 1'b0;
                    done_o      <= 1'b0;
                    busy_o      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_valid_o <= 1'b0;
                    done_o      <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter PIX_W, default 14, meaning the width of pixel index/length fields (covers 127*127 outputs).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start_i  in  1  one-cycle layer start pulse; abort_i  in  1  synchronous abort.
REQ-004 SHALL have ports: in_D_i  in  11  input channels; out_K_i  in  11  output channels; tile_D_i  in  7  D tile size; tile_K_i  in  7  K tile size.
REQ-005 SHALL have ports: tile_n_i  in  32  pixels per spatial tile; out_R_i  in  7  ofmap rows; out_C_i  in  7  ofmap cols.
REQ-006 SHALL have ports: cmd_valid_o  out  1; cmd_ready_i  in  1; k_base_o  out  11; k_len_o  out  7; d_base_o  out  11; d_len_o  out  7; pix_base_o  out  PIX_W; pix_len_o  out  PIX_W.
REQ-007 SHALL have ports: first_d_o  out  1  first D tile of accumulation (clear psum); last_d_o  out  1  last D tile (write back ofmap).
REQ-008 SHALL have ports: busy_o  out  1; done_o  out  1  one-cycle completion pulse; err_o  out  1  sticky config error.

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ISSUE, DONE.
REQ-010 IDLE: start_i=1 -> SETUP; start_i in any other state SHALL be ignored.
REQ-011 SETUP (1 cycle): latch all *_i parameters; compute P = out_R_i*out_C_i; chunk = min(tile_n_i, P) truncated to PIX_W.
REQ-012 SETUP: if any of in_D, out_K, tile_D, tile_K, out_R, out_C, tile_n is 0 -> set err_o, go DONE, issue no command; else clear err_o, go ISSUE.
REQ-013 Loop order SHALL be K tile outermost, pixel chunk middle, D tile innermost; bases start at 0.
REQ-014 Lengths SHALL be clipped at edges: k_len=min(tile_K, out_K-k_base), d_len=min(tile_D, in_D-d_base), pix_len=min(chunk, P-pix_base).
REQ-015 first_d_o=1 iff d_base==0; last_d_o=1 iff d_base+d_len==in_D.
REQ-016 ISSUE: cmd_valid_o=1; command fields SHALL be registered and stable while cmd_valid_o=1 and cmd_ready_i=0.
REQ-017 Handshake: transfer when cmd_valid_o & cmd_ready_i; next command presented the following cycle (back-to-back throughput 1 cmd/cycle).
REQ-018 After transfer of command with last D, last pixel chunk and last K tile -> DONE, cmd_valid_o=0 same edge.
REQ-019 DONE (1 cycle): done_o=1 -> IDLE.
REQ-020 busy_o=1 in SETUP, ISSUE, DONE; 0 in IDLE.
REQ-021 Counter increments SHALL use >=12-bit intermediates; no wrap-around on 11-bit channel or PIX_W pixel bases.
REQ-022 abort_i in SETUP or ISSUE SHALL drop cmd_valid_o next cycle and go DONE (done_o pulse); abort_i has priority over simultaneous handshake; ignored in IDLE/DONE.
REQ-023 Total commands SHALL equal ceil(out_K/tile_K)*ceil(P/chunk)*ceil(in_D/tile_D).

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, all counters 0, all outputs 0 (including err_o), including mid-ISSUE with cmd_valid_o high.
REQ-025 After rst_n release, no command SHALL issue until a new start_i.

Verification
REQ-026 in_D=64,out_K=64,tile_D=tile_K=32,out_R=out_C=4,tile_n=16, ready=1 -> 4 cmds: (k0,d0,first),(k0,d32,last),(k32,d0,first),(k32,d32,last), pix 0/16, done_o 1 cycle after 4th.
REQ-027 in_D=10,out_K=25,tile_D=tile_K=10,out_R=out_C=3,tile_n=4 -> 3*3*1=9 cmds; last K k_len=5; pix_len sequence 4,4,1; first_d=last_d=1 on all.
REQ-028 Random cmd_ready_i stalls -> fields stable during stall; sequence identical to no-stall run.
REQ-029 tile_n=0 or out_K=0 -> err_o=1, zero cmds, done_o pulse 2 cycles after start_i.
REQ-030 abort_i on 2nd command while ready=0 -> cmd_valid_o low next cycle, done_o pulse, start_i again -> full sequence restarts from bases 0.
REQ-031 rst_n asserted mid-ISSUE -> outputs 0 immediately; start_i re-issued -> correct full sequence.
